ahb_lite_xbar_n: RTL and testbench

Parametrised single-master AHB-Lite interconnect between the Cortex-M0 system bus and NPORT slaves. Successor to the fixed four-port interconnect:
- address decode from a parameter table instead of hard-coded regions;
- built-in default slave that returns a two-cycle ERROR for unmapped accesses;
- per-port wait-state timeout, so a hung slave cannot lock the core.

Sits between the core's AHB master port and the RAM, GPIO and UART bridges.

---
 rtl/ahb_lite_xbar_n_if.sv | 34 +++
 rtl/ahb_lite_xbar_n.sv | 192 +++++++++++++++++++
 tb/tb_ahb_lite_xbar_n.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_xbar_n_if.sv
// AHB-Lite bus bundle shared by the system-bus master, the interconnect and its NPORT slave ports.
// The interconnect uses the slave view; the master and slave models use the master view.
interface ahb_lite_xbar_n_if #(
    parameter int NPORT = 4
);
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic [2:0]          HSIZE;
    logic [2:0]          HBURST;
    logic [3:0]          HPROT;
    logic                HMASTLOCK;
    logic                HWRITE;
    logic [31:0]         HWDATA;
    logic [31:0]         HRDATA;
    logic                HREADY;
    logic                HRESP;
    logic [NPORT-1:0]    HSEL_P;
    logic [NPORT-1:0]    HREADY_P;
    logic [NPORT-1:0]    HREADYOUT_P;
    logic [NPORT-1:0]    HRESP_P;
    logic [NPORT*32-1:0] HRDATA_P;

    modport slave (
        input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
        input  HREADYOUT_P, HRESP_P, HRDATA_P,
        output HRDATA, HREADY, HRESP, HSEL_P, HREADY_P
    );

    modport master (
        output HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
        output HREADYOUT_P, HRESP_P, HRDATA_P,
        input  HRDATA, HREADY, HRESP, HSEL_P, HREADY_P
    );
endinterface

// File: rtl/ahb_lite_xbar_n.sv
// Single-master AHB-Lite interconnect: table-driven decode, built-in error slave and
// per-transfer wait-state timeout so a hung slave cannot stall the core forever.
module ahb_lite_xbar_n #(
    parameter int                  NPORT     = 4,
    parameter logic [NPORT*32-1:0] ADDR_BASE = {32'h4001_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NPORT*32-1:0] ADDR_MASK = {4{32'hFFFF_0000}},
    parameter int                  TIMEOUT   = 256
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_lite_xbar_n_if.slave   bus,
    output logic [NPORT-1:0]   TIMEOUT_FLAG
);
    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PASS  = 3'd1,
        ST_ERR1  = 3'd2,
        ST_ERR2  = 3'd3,
        ST_TOUT1 = 3'd4,
        ST_TOUT2 = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    state_t             decode_nxt_s;
    logic [IDX_W-1:0]   owner_r;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [NPORT-1:0]   flag_r;
    logic [IDX_W-1:0]   match_idx_s;
    logic               match_hit_s;
    logic [NPORT-1:0]   hsel_s;
    logic               owner_ready_s;
    logic               owner_resp_s;
    logic [31:0]        owner_rdata_s;
    logic               timeout_hit_s;
    logic               hready_s;
    logic               hresp_s;
    logic [31:0]        hrdata_s;
    logic               unused_ctrl_s;

    // Address decode: scanning downwards lets the lowest matching index win on overlap
    always_comb begin
        match_idx_s = {IDX_W{1'b0}};
        match_hit_s = 1'b0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if ((bus.HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) begin
                match_idx_s = IDX_W'(i);
                match_hit_s = 1'b1;
            end else begin
                match_idx_s = match_idx_s;
                match_hit_s = match_hit_s;
            end
        end
    end

    // One-hot slave select, only for active (NONSEQ/SEQ) transfers that hit a region
    always_comb begin
        hsel_s = {NPORT{1'b0}};
        if (bus.HTRANS[1] && match_hit_s) begin
            hsel_s[match_idx_s] = 1'b1;
        end else begin
            hsel_s = {NPORT{1'b0}};
        end
    end

    // Data-phase kind implied by the address phase currently on the bus
    always_comb begin
        if (!bus.HTRANS[1]) begin
            decode_nxt_s = ST_IDLE;
        end else if (match_hit_s) begin
            decode_nxt_s = ST_PASS;
        end else begin
            decode_nxt_s = ST_ERR1;
        end
    end

    assign owner_ready_s = bus.HREADYOUT_P[owner_r];
    assign owner_resp_s  = bus.HRESP_P[owner_r];
    assign owner_rdata_s = bus.HRDATA_P[32*owner_r +: 32];
    assign timeout_hit_s = (TIMEOUT != 0) && (state_r == ST_PASS) && !owner_ready_s
                           && (wait_cnt_r == CNT_LAST);

    // FSM state register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; a timed-out transfer is finished with the two-cycle ERROR
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERR2, ST_TOUT2: state_nxt_s = decode_nxt_s;
            ST_PASS: begin
                if (timeout_hit_s) begin
                    state_nxt_s = ST_TOUT1;
                end else if (owner_ready_s) begin
                    state_nxt_s = decode_nxt_s;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            ST_ERR1:  state_nxt_s = ST_ERR2;
            ST_TOUT1: state_nxt_s = ST_TOUT2;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs; reset forces a quiet OKAY response immediately
    always_comb begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
        hrdata_s = 32'h0000_0000;
        if (HRESET) begin
            hready_s = 1'b1;
            hresp_s  = 1'b0;
            hrdata_s = 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hready_s = 1'b1;
                    hresp_s  = 1'b0;
                end
                ST_PASS: begin
                    hready_s = owner_ready_s;
                    hresp_s  = owner_resp_s;
                    hrdata_s = owner_rdata_s;
                end
                ST_ERR1, ST_TOUT1: begin
                    hready_s = 1'b0;
                    hresp_s  = 1'b1;
                end
                ST_ERR2, ST_TOUT2: begin
                    hready_s = 1'b1;
                    hresp_s  = 1'b1;
                end
                default: begin
                    hready_s = 1'b1;
                    hresp_s  = 1'b0;
                end
            endcase
        end
    end

    // Data-phase owner is taken on every edge that completes a transfer
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner_r <= {IDX_W{1'b0}};
        end else if (hready_s) begin
            owner_r <= match_idx_s;
        end
    end

    // Saturating wait-state counter, restarted by every completed transfer
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (hready_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_PASS) && !owner_ready_s && (wait_cnt_r != CNT_MAX)) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
        end
    end

    // Sticky per-port timeout record, cleared only by reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            flag_r <= {NPORT{1'b0}};
        end else if (timeout_hit_s) begin
            flag_r[owner_r] <= 1'b1;
        end
    end

    assign bus.HSEL_P   = hsel_s;
    assign bus.HREADY   = hready_s;
    assign bus.HREADY_P = {NPORT{hready_s}};
    assign bus.HRESP    = hresp_s;
    assign bus.HRDATA   = hrdata_s;
    assign TIMEOUT_FLAG = flag_r;

    // Slaves take these straight from the master; the interconnect never looks at them
    assign unused_ctrl_s = ^{bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK,
                             bus.HWRITE, bus.HWDATA, bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb_lite_xbar_n.sv
// Bench for ahb_lite_xbar_n: directed scenarios plus a randomized pipelined transfer stream
// checked against a transaction-level model of what the master should observe.
module tb_ahb_lite_xbar_n;
    localparam int NPORT = 4;
    localparam int TOUT  = 8;
    localparam int NRAND = 60;
    localparam int RAND_LIMIT = 2000;

    logic HCLK = 1'b0;
    logic HRESET;
    logic [NPORT-1:0] tflag;
    logic [NPORT-1:0] tflag_b;
    int vectors = 0;
    int miscompares = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_xbar_n_if #(.NPORT(NPORT)) bus ();
    ahb_lite_xbar_n_if #(.NPORT(NPORT)) bus_b ();

    ahb_lite_xbar_n #(.NPORT(NPORT), .TIMEOUT(TOUT)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus.slave), .TIMEOUT_FLAG(tflag)
    );

    // Second instance with P2 and P3 sharing one region, for the priority rule
    ahb_lite_xbar_n #(
        .NPORT(NPORT),
        .ADDR_BASE({32'h4000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
        .TIMEOUT(TOUT)
    ) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus_b.slave), .TIMEOUT_FLAG(tflag_b)
    );

    typedef struct {
        int          kind;   // 0 idle/busy, 1 mapped port, 2 unmapped
        int          port;
        int          waits;
        logic        err;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic [31:0] bases [4] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h4001_0000};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag, input logic rdy, input logic resp, input logic [31:0] rdata);
        check({tag, ".hready"}, bus.HREADY, rdy);
        check({tag, ".hresp"}, bus.HRESP, resp);
        check({tag, ".hrdata"}, bus.HRDATA, rdata);
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic [1:0] t, input logic w);
        bus.HADDR     = a;
        bus.HTRANS    = t;
        bus.HWRITE    = w;
        bus.HWDATA    = $urandom;
        bus.HSIZE     = 3'b010;
        bus.HBURST    = 3'b000;
        bus.HPROT     = 4'b0011;
        bus.HMASTLOCK = 1'b0;
    endtask

    task automatic quiet_slaves();
        bus.HREADYOUT_P = 4'b1111;
        bus.HRESP_P     = 4'b0000;
        bus.HRDATA_P    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_lane(input int p, input logic [31:0] d);
        bus.HRDATA_P[32*p +: 32] = d;
    endtask

    function automatic xfer_t idle_xfer();
        xfer_t x;
        x.kind = 0; x.port = 0; x.waits = 0; x.err = 1'b0;
        x.trans = 2'b00; x.addr = $urandom; x.data = 32'h0000_0000;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int pick;
        logic [15:0] ofs;
        x = idle_xfer();
        pick = $urandom_range(0, 9);
        ofs = 16'($urandom) & 16'hFFFC;
        if (pick < 2) begin
            x.trans = 2'($urandom_range(0, 1));
        end else if (pick == 2) begin
            x.kind = 2; x.trans = 2'b10; x.addr = {16'h6000, ofs};
        end else begin
            x.kind = 1; x.port = $urandom_range(0, 3); x.trans = 2'($urandom_range(2, 3));
            x.addr = {bases[x.port][31:16], ofs};
            x.waits = $urandom_range(0, 3);
            x.err = ($urandom_range(0, 7) == 0);
            x.data = $urandom;
        end
        return x;
    endfunction

    initial begin
        xfer_t cur, nxt;
        int cyc, issued, budget;
        logic exp_rdy, exp_resp;
        logic [31:0] exp_data, lane;
        logic [3:0] exp_sel;

        HRESET = 1'b1;
        drive_addr(32'h0000_0000, 2'b00, 1'b0);
        quiet_slaves();
        bus_b.HADDR = 32'h0000_0000; bus_b.HTRANS = 2'b00; bus_b.HSIZE = 3'b010;
        bus_b.HBURST = 3'b000; bus_b.HPROT = 4'b0011; bus_b.HMASTLOCK = 1'b0;
        bus_b.HWRITE = 1'b0; bus_b.HWDATA = 32'h0000_0000;
        bus_b.HREADYOUT_P = 4'b1111; bus_b.HRESP_P = 4'b0000; bus_b.HRDATA_P = {4{32'h0000_0000}};
        repeat (2) @(posedge HCLK);

        // Reset / idle
        @(negedge HCLK); HRESET = 1'b0; #1;
        check_resp("reset", 1'b1, 1'b0, 32'h0000_0000);
        check("reset.hsel", bus.HSEL_P, 4'b0000);
        check("reset.flag", tflag, 4'b0000);

        // Read to P1 with two wait states
        @(negedge HCLK); drive_addr(32'h2000_0004, 2'b10, 1'b0); #1;
        check("p1.hsel", bus.HSEL_P, 4'b0010);
        check("p1.addr_hready", bus.HREADY, 1'b1);
        @(negedge HCLK); drive_addr(32'h0000_0000, 2'b00, 1'b0); bus.HREADYOUT_P[1] = 1'b0; #1;
        check("p1.wait1", bus.HREADY, 1'b0);
        check("p1.wait1_hsel", bus.HSEL_P, 4'b0000);
        @(negedge HCLK); #1;
        check("p1.wait2", bus.HREADY, 1'b0);
        @(negedge HCLK); bus.HREADYOUT_P[1] = 1'b1; set_lane(1, 32'hDEAD_BEEF); #1;
        check_resp("p1.done", 1'b1, 1'b0, 32'hDEAD_BEEF);
        @(negedge HCLK); quiet_slaves(); #1;
        check_resp("p1.after", 1'b1, 1'b0, 32'h0000_0000);

        // Unmapped write answered by the default slave
        @(negedge HCLK); drive_addr(32'h6000_0000, 2'b10, 1'b1); #1;
        check("unmap.hsel", bus.HSEL_P, 4'b0000);
        @(negedge HCLK); drive_addr(32'h0000_0000, 2'b00, 1'b0); #1;
        check_resp("unmap.err1", 1'b0, 1'b1, 32'h0000_0000);
        @(negedge HCLK); #1;
        check_resp("unmap.err2", 1'b1, 1'b1, 32'h0000_0000);
        @(negedge HCLK); #1;
        check_resp("unmap.okay", 1'b1, 1'b0, 32'h0000_0000);

        // Pipelined: write P0 (1 wait) then read P3 overlapping its data phase
        @(negedge HCLK); drive_addr(32'h0000_0010, 2'b10, 1'b1); #1;
        check("pipe.hsel0", bus.HSEL_P, 4'b0001);
        @(negedge HCLK); drive_addr(32'h4001_0000, 2'b10, 1'b0); bus.HREADYOUT_P[0] = 1'b0; #1;
        check("pipe.p0_wait", bus.HREADY, 1'b0);
        check("pipe.hsel3_wait", bus.HSEL_P, 4'b1000);
        @(negedge HCLK); bus.HREADYOUT_P[0] = 1'b1; #1;
        check("pipe.p0_done", bus.HREADY, 1'b1);
        check("pipe.hsel3_done", bus.HSEL_P, 4'b1000);
        @(negedge HCLK); drive_addr(32'h0000_0000, 2'b00, 1'b0);
        bus.HREADYOUT_P[0] = 1'b0; set_lane(3, 32'h1234_5678); #1;
        check_resp("pipe.p3", 1'b1, 1'b0, 32'h1234_5678);
        @(negedge HCLK); quiet_slaves(); #1;
        check("pipe.idle", bus.HREADY, 1'b1);

        // Randomized pipelined stream against the transaction-level model
        cur = idle_xfer(); nxt = rand_xfer(); cyc = 0; issued = 1; budget = 0;
        while (!(issued >= NRAND && cur.kind == 0 && nxt.kind == 0) && budget < RAND_LIMIT) begin
            @(negedge HCLK);
            budget++;
            drive_addr(nxt.addr, nxt.trans, 1'($urandom));
            bus.HREADYOUT_P = 4'($urandom);
            bus.HRESP_P     = 4'($urandom);
            bus.HRDATA_P    = {$urandom, $urandom, $urandom, $urandom};
            exp_rdy = 1'b1; exp_resp = 1'b0; exp_data = 32'h0000_0000;
            if (cur.kind == 1) begin
                lane = (cyc >= cur.waits) ? cur.data : $urandom;
                bus.HREADYOUT_P[cur.port] = (cyc >= cur.waits);
                bus.HRESP_P[cur.port] = cur.err;
                set_lane(cur.port, lane);
                exp_rdy = (cyc >= cur.waits); exp_resp = cur.err; exp_data = lane;
            end else if (cur.kind == 2) begin
                exp_rdy = (cyc == 1); exp_resp = 1'b1;
            end
            exp_sel = (nxt.kind == 1) ? (4'b0001 << nxt.port) : 4'b0000;
            #1;
            check_resp("rand", exp_rdy, exp_resp, exp_data);
            check("rand.hsel", bus.HSEL_P, exp_sel);
            check("rand.hready_p", bus.HREADY_P, {4{exp_rdy}});
            if (exp_rdy) begin
                cur = nxt; cyc = 0;
                nxt = (issued < NRAND) ? rand_xfer() : idle_xfer();
                issued++;
            end else begin
                cyc++;
            end
        end
        check("rand.budget", budget < RAND_LIMIT, 1'b1);
        @(negedge HCLK); drive_addr(32'h0000_0000, 2'b00, 1'b0); quiet_slaves(); #1;
        check("rand.flag", tflag, 4'b0000);

        // Timeout on P2: 8 wait cycles, then ERR1/ERR2, late response discarded
        @(negedge HCLK); drive_addr(32'h4000_0020, 2'b10, 1'b0); bus.HREADYOUT_P[2] = 1'b0; #1;
        check("tout.hsel", bus.HSEL_P, 4'b0100);
        for (int k = 0; k < TOUT; k++) begin
            @(negedge HCLK); drive_addr(32'h0000_0000, 2'b00, 1'b0); #1;
            check_resp($sformatf("tout.wait%0d", k), 1'b0, 1'b0, bus.HRDATA_P[2*32 +: 32]);
        end
        @(negedge HCLK); bus.HREADYOUT_P[2] = 1'b1; set_lane(2, 32'hBAD0_BAD0); #1;
        check_resp("tout.err1", 1'b0, 1'b1, 32'h0000_0000);
        check("tout.flag_set", tflag, 4'b0100);
        @(negedge HCLK); #1;
        check_resp("tout.err2", 1'b1, 1'b1, 32'h0000_0000);
        @(negedge HCLK); quiet_slaves(); #1;
        check_resp("tout.okay", 1'b1, 1'b0, 32'h0000_0000);

        // Flagged P2 still serves a later 1-wait access
        @(negedge HCLK); drive_addr(32'h4000_0040, 2'b10, 1'b0); #1;
        check("p2again.hsel", bus.HSEL_P, 4'b0100);
        @(negedge HCLK); drive_addr(32'h0000_0000, 2'b00, 1'b0); bus.HREADYOUT_P[2] = 1'b0; #1;
        check("p2again.wait", bus.HREADY, 1'b0);
        @(negedge HCLK); bus.HREADYOUT_P[2] = 1'b1; set_lane(2, 32'hCAFE_F00D); #1;
        check_resp("p2again.done", 1'b1, 1'b0, 32'hCAFE_F00D);
        @(negedge HCLK); quiet_slaves(); #1;
        check("p2again.flag", tflag, 4'b0100);

        // Reset in the middle of a waited transfer
        @(negedge HCLK); drive_addr(32'h2000_0000, 2'b10, 1'b0); #1;
        @(negedge HCLK); drive_addr(32'h0000_0000, 2'b00, 1'b0); bus.HREADYOUT_P[1] = 1'b0; #1;
        check("rst_mid.wait", bus.HREADY, 1'b0);
        @(negedge HCLK); HRESET = 1'b1; #1;
        check_resp("rst_mid.during", 1'b1, 1'b0, 32'h0000_0000);
        @(negedge HCLK); HRESET = 1'b0; #1;
        check_resp("rst_mid.after", 1'b1, 1'b0, 32'h0000_0000);
        check("rst_mid.flag", tflag, 4'b0000);

        // Overlapping regions: lowest index wins
        @(negedge HCLK); bus_b.HADDR = 32'h4000_0000; bus_b.HTRANS = 2'b10; #1;
        check("overlap.hsel", bus_b.HSEL_P, 4'b0100);
        @(negedge HCLK); bus_b.HADDR = 32'h4001_0000; #1;
        check("overlap.unmapped", bus_b.HSEL_P, 4'b0000);
        @(negedge HCLK); bus_b.HADDR = 32'h4000_0000; bus_b.HTRANS = 2'b01; #1;
        check("overlap.busy", bus_b.HSEL_P, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
